bnn_seq_cxu: RTL and testbench

//  Multi-cycle binary-neural-net dot-product CXU with valid/ready request/response handshakes.

---
 rtl/bnn_seq_cxu.sv | 137 +++++++++++++
 tb/tb_bnn_seq_cxu.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_seq_cxu.sv
// Sequential binary-neural-net CXU: popcount(a XNOR b) over CHUNK_W bits per cycle,
// with one wrapping accumulator per state context so partial sums build across requests.
module bnn_seq_cxu #(
  parameter int CXU_N_CXUS     = 1,
  parameter int CXU_CXU_ID_W   = 1,
  parameter int CXU_FUNC_ID_W  = 3,
  parameter int CXU_N_STATES   = 4,
  parameter int CXU_STATE_ID_W = 2,
  parameter int CXU_DATA_W     = 32,
  parameter int CHUNK_W        = 8,
  parameter int CXU_STATUS_W   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clk_en,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [CXU_CXU_ID_W-1:0]   req_cxu,
  input  logic [CXU_STATE_ID_W-1:0] req_state,
  input  logic [CXU_FUNC_ID_W-1:0]  req_func,
  input  logic [CXU_DATA_W-1:0]     req_data0,
  input  logic [CXU_DATA_W-1:0]     req_data1,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [CXU_STATUS_W-1:0]   resp_status,
  output logic [CXU_DATA_W-1:0]     resp_data
);

  localparam logic [CXU_STATUS_W-1:0] CXU_STATUS_SUCCESS = '0;
  localparam logic [CXU_STATUS_W-1:0] CXU_STATUS_ERROR   = CXU_STATUS_W'(1);

  localparam int N_CHUNKS = CXU_DATA_W / CHUNK_W;
  localparam int POP_W    = $clog2(CXU_DATA_W) + 1;
  localparam int CNT_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(N_CHUNKS - 1);

  localparam logic [CXU_FUNC_ID_W-1:0] FUNC_BNN        = CXU_FUNC_ID_W'(0);
  localparam logic [CXU_FUNC_ID_W-1:0] FUNC_BNN_ACC    = CXU_FUNC_ID_W'(1);
  localparam logic [CXU_FUNC_ID_W-1:0] FUNC_ACC_RD_CLR = CXU_FUNC_ID_W'(2);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t state, state_next;

  logic [CXU_DATA_W-1:0]     acc [CXU_N_STATES];
  logic [CXU_DATA_W-1:0]     xnor_q;
  logic [CXU_FUNC_ID_W-1:0]  func_q;
  logic [CXU_STATE_ID_W-1:0] sel_q;
  logic [CNT_W-1:0]          cnt;
  logic [POP_W-1:0]          partial;
  logic [POP_W-1:0]          chunk_sum;
  logic [CXU_DATA_W-1:0]     acc_sum;
  logic                      is_dot;
  logic                      cxu_unused;

  // Only one CXU sits on this mux, so the id is deliberately ignored.
  assign cxu_unused = (CXU_N_CXUS > 0) & (^req_cxu);

  function automatic logic [POP_W-1:0] popcount(input logic [CHUNK_W-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < CHUNK_W; i++) n = n + POP_W'(v[i]);
    return n;
  endfunction

  assign is_dot    = (req_func == FUNC_BNN) || (req_func == FUNC_BNN_ACC);
  assign chunk_sum = partial + popcount(xnor_q[int'(cnt) * CHUNK_W +: CHUNK_W]);
  assign acc_sum   = acc[sel_q] + CXU_DATA_W'(chunk_sum);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else if (clk_en) state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = is_dot ? BUSY : RESP;
      BUSY:    if (cnt == LAST_CHUNK) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
  end

  // The accumulator is folded at BUSY exit, so a stalled response can never re-apply it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CXU_N_STATES; i++) acc[i] <= '0;
      xnor_q      <= '0;
      func_q      <= '0;
      sel_q       <= '0;
      cnt         <= '0;
      partial     <= '0;
      resp_data   <= '0;
      resp_status <= CXU_STATUS_SUCCESS;
    end else if (clk_en) begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            xnor_q      <= ~(req_data0 ^ req_data1);
            func_q      <= req_func;
            sel_q       <= req_state;
            cnt         <= '0;
            partial     <= '0;
            resp_status <= CXU_STATUS_SUCCESS;
            if (req_func == FUNC_ACC_RD_CLR) begin
              resp_data      <= acc[req_state];
              acc[req_state] <= '0;
            end else if (!is_dot) begin
              resp_data   <= '0;
              resp_status <= CXU_STATUS_ERROR;
            end
          end
        end
        BUSY: begin
          partial <= chunk_sum;
          cnt     <= cnt + CNT_W'(1);
          if (cnt == LAST_CHUNK) begin
            if (func_q == FUNC_BNN_ACC) begin
              acc[sel_q] <= acc_sum;
              resp_data  <= acc_sum;
            end else begin
              resp_data <= CXU_DATA_W'(chunk_sum);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_seq_cxu.sv
// Self-checking bench for bnn_seq_cxu: a 32/8 and a 64/16 instance, scoreboard of expected
// responses computed from a behavioural accumulator model.
module tb_bnn_seq_cxu;

  logic        clk = 1'b0;
  logic        rst, clk_en, resp_ready, cxu_id;
  logic        v32, v64;
  logic [2:0]  func;
  logic [1:0]  sel;
  logic [63:0] a, b;
  logic        r32, rv32, s32, r64, rv64, s64;
  logic [31:0] d32;
  logic [63:0] d64;

  typedef struct {
    logic [63:0] data;
    logic        status;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] macc [2][4];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  bnn_seq_cxu #(.CXU_DATA_W(32), .CHUNK_W(8)) dut32 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .req_valid(v32), .req_ready(r32),
    .req_cxu(cxu_id), .req_state(sel), .req_func(func), .req_data0(a[31:0]),
    .req_data1(b[31:0]), .resp_valid(rv32), .resp_ready(resp_ready),
    .resp_status(s32), .resp_data(d32));

  bnn_seq_cxu #(.CXU_DATA_W(64), .CHUNK_W(16)) dut64 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .req_valid(v64), .req_ready(r64),
    .req_cxu(cxu_id), .req_state(sel), .req_func(func), .req_data0(a),
    .req_data1(b), .resp_valid(rv64), .resp_ready(resp_ready),
    .resp_status(s64), .resp_data(d64));

  function automatic void clear_model();
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 4; i++) macc[w][i] = '0;
  endfunction

  function automatic exp_t model(input int w, input logic [2:0] f, input logic [1:0] st,
                                 input logic [63:0] x, input logic [63:0] y);
    exp_t r;
    logic [63:0] m, pc;
    m = w != 0 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    pc = 64'($countones(~(x ^ y) & m));
    r.status = 1'b0;
    r.lat = 1;
    r.data = '0;
    case (f)
      3'd0: begin r.data = pc; r.lat = 5; end
      3'd1: begin
        macc[w][st] = (macc[w][st] + pc) & m;
        r.data = macc[w][st];
        r.lat = 5;
      end
      3'd2: begin r.data = macc[w][st]; macc[w][st] = '0; end
      default: r.status = 1'b1;
    endcase
    return r;
  endfunction

  // Drives one request, measures latency, holds off resp_ready for bp cycles, completes handshake.
  task automatic run_op(input int w, input logic [2:0] f, input logic [1:0] st,
                        input logic [63:0] x, input logic [63:0] y,
                        input int stall_at, input int stall_len, input int bp,
                        output logic [63:0] d, output logic s, output int lat,
                        output bit to, output int bp_bad);
    int g;
    to = 1'b0; lat = 0; bp_bad = 0; d = '0; s = 1'b0;
    @(negedge clk);
    func = f; sel = st; a = x; b = y; clk_en = 1'b1; resp_ready = (bp == 0);
    if (w != 0) v64 = 1'b1; else v32 = 1'b1;
    g = 0;
    while (!(w != 0 ? r64 : r32) && g < 50) begin @(negedge clk); g++; end
    if (g >= 50) begin to = 1'b1; v32 = 1'b0; v64 = 1'b0; return; end
    @(negedge clk);
    v32 = 1'b0; v64 = 1'b0; lat = 1;
    while (!(w != 0 ? rv64 : rv32) && lat < 100) begin
      clk_en = !(lat >= stall_at && lat < stall_at + stall_len);
      @(negedge clk);
      lat++;
    end
    clk_en = 1'b1;
    if (lat >= 100) begin to = 1'b1; resp_ready = 1'b1; return; end
    d = w != 0 ? d64 : {32'h0, d32};
    s = w != 0 ? s64 : s32;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      if ((w != 0 ? d64 : {32'h0, d32}) != d || (w != 0 ? r64 : r32) || !(w != 0 ? rv64 : rv32))
        bp_bad++;
    end
    resp_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (r32 !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready32: got %0b expected 1", r32); end
    checks++; if (rv32 !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid32: got %0b expected 0", rv32); end
    checks++; if (d32 !== 32'h0) begin errors++; $display("[TB] FAIL reset_data32: got %0h expected 0", d32); end
    checks++; if (s32 !== 1'b0) begin errors++; $display("[TB] FAIL reset_status32: got %0b expected 0", s32); end
    checks++; if (r64 !== 1'b1 || rv64 !== 1'b0) begin errors++; $display("[TB] FAIL reset_hs64: got ready=%0b valid=%0b expected 1/0", r64, rv64); end
    rst = 1'b0;
    clear_model();
  endtask

  task automatic test_bnn();
    logic [63:0] xs[3], ys[3], d;
    logic s; int lat, bb; bit to; exp_t e;
    xs[0] = 64'hFFFF_0000; ys[0] = 64'hFFFF_FFFF;
    xs[1] = 64'h1234_5678; ys[1] = 64'h1234_5678;
    xs[2] = {32'h0, $urandom}; ys[2] = {32'h0, $urandom};
    for (int i = 0; i < 3; i++) begin
      sb.push_back(model(0, 3'd0, 2'd0, xs[i], ys[i]));
      run_op(0, 3'd0, 2'd0, xs[i], ys[i], 0, 0, 0, d, s, lat, to, bb);
      e = sb.pop_front();
      checks++; if (d !== e.data) begin errors++; $display("[TB] FAIL bnn_data[%0d]: got %0h expected %0h", i, d, e.data); end
      checks++; if (s !== e.status) begin errors++; $display("[TB] FAIL bnn_status[%0d]: got %0b expected %0b", i, s, e.status); end
      checks++; if (to || lat != e.lat) begin errors++; $display("[TB] FAIL bnn_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
    end
  endtask

  task automatic test_acc();
    logic [2:0] fs[6];
    logic [1:0] ss[6];
    logic [63:0] d; logic s; int lat, bb; bit to; exp_t e;
    fs = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2};
    ss = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
    for (int i = 0; i < 6; i++) begin
      sb.push_back(model(0, fs[i], ss[i], 64'h0, 64'h0));
      run_op(0, fs[i], ss[i], 64'h0, 64'h0, 0, 0, 0, d, s, lat, to, bb);
      e = sb.pop_front();
      checks++; if (d !== e.data) begin errors++; $display("[TB] FAIL acc_data[%0d]: got %0d expected %0d", i, d, e.data); end
      checks++; if (to || lat != e.lat) begin errors++; $display("[TB] FAIL acc_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] d; logic s; int lat, bb; bit to; exp_t e;
    sb.push_back(model(0, 3'd1, 2'd2, 64'h0, 64'h0));
    run_op(0, 3'd1, 2'd2, 64'h0, 64'h0, 0, 0, 10, d, s, lat, to, bb);
    e = sb.pop_front();
    checks++; if (d !== e.data) begin errors++; $display("[TB] FAIL bp_data: got %0d expected %0d", d, e.data); end
    checks++; if (to || bb != 0) begin errors++; $display("[TB] FAIL bp_stable: got %0d bad cycles expected 0", bb); end
    checks++; if (r32 !== 1'b1 || rv32 !== 1'b0) begin errors++; $display("[TB] FAIL bp_idle: got ready=%0b valid=%0b expected 1/0", r32, rv32); end
    sb.push_back(model(0, 3'd2, 2'd2, 64'h0, 64'h0));
    run_op(0, 3'd2, 2'd2, 64'h0, 64'h0, 0, 0, 0, d, s, lat, to, bb);
    e = sb.pop_front();
    checks++; if (d !== e.data) begin errors++; $display("[TB] FAIL bp_readback: got %0d expected %0d", d, e.data); end
  endtask

  task automatic test_error();
    logic [2:0] fs[3];
    logic [63:0] d; logic s; int lat, bb; bit to; exp_t e;
    fs = '{3'd1, 3'd5, 3'd2};
    for (int i = 0; i < 3; i++) begin
      sb.push_back(model(0, fs[i], 2'd3, 64'hFFFF_0000, 64'h0));
      run_op(0, fs[i], 2'd3, 64'hFFFF_0000, 64'h0, 0, 0, 0, d, s, lat, to, bb);
      e = sb.pop_front();
      checks++; if (d !== e.data) begin errors++; $display("[TB] FAIL err_data[%0d]: got %0h expected %0h", i, d, e.data); end
      checks++; if (s !== e.status) begin errors++; $display("[TB] FAIL err_status[%0d]: got %0b expected %0b", i, s, e.status); end
      checks++; if (to || lat != e.lat) begin errors++; $display("[TB] FAIL err_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [63:0] d; logic s; int lat, bb; bit to; exp_t e;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(model(0, 3'd1, 2'(i), 64'h0, 64'h0));
      run_op(0, 3'd1, 2'(i), 64'h0, 64'h0, 0, 0, 0, d, s, lat, to, bb);
      e = sb.pop_front();
      checks++; if (d !== e.data) begin errors++; $display("[TB] FAIL rstb_pre[%0d]: got %0d expected %0d", i, d, e.data); end
    end
    @(negedge clk);
    func = 3'd1; sel = 2'd0; a = '0; b = '0; v32 = 1'b1;
    @(negedge clk);
    v32 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (r32 !== 1'b1 || rv32 !== 1'b0) begin errors++; $display("[TB] FAIL rstb_hs: got ready=%0b valid=%0b expected 1/0", r32, rv32); end
    checks++; if (d32 !== 32'h0 || s32 !== 1'b0) begin errors++; $display("[TB] FAIL rstb_resp: got data=%0h status=%0b expected 0/0", d32, s32); end
    rst = 1'b0;
    clear_model();
    for (int i = 0; i < 4; i++) begin
      sb.push_back(model(0, 3'd2, 2'(i), 64'h0, 64'h0));
      run_op(0, 3'd2, 2'(i), 64'h0, 64'h0, 0, 0, 0, d, s, lat, to, bb);
      e = sb.pop_front();
      checks++; if (to || d !== e.data) begin errors++; $display("[TB] FAIL rstb_acc[%0d]: got %0d expected %0d", i, d, e.data); end
    end
  endtask

  task automatic test_wide();
    logic [63:0] x, d; logic s; int lat, bb; bit to; exp_t e;
    logic [2:0] fs[4];
    int stl[4];
    x = {$urandom, $urandom};
    fs = '{3'd0, 3'd0, 3'd1, 3'd2};
    stl = '{0, 3, 0, 0};
    for (int i = 0; i < 4; i++) begin
      e = model(1, fs[i], 2'd1, x, i < 2 ? ~x : x);
      e.lat = e.lat + stl[i];
      sb.push_back(e);
      run_op(1, fs[i], 2'd1, x, i < 2 ? ~x : x, 2, stl[i], 0, d, s, lat, to, bb);
      e = sb.pop_front();
      checks++; if (d !== e.data) begin errors++; $display("[TB] FAIL wide_data[%0d]: got %0h expected %0h", i, d, e.data); end
      checks++; if (to || lat != e.lat) begin errors++; $display("[TB] FAIL wide_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
    end
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b1; resp_ready = 1'b1; cxu_id = 1'b0;
    v32 = 1'b0; v64 = 1'b0; func = '0; sel = '0; a = '0; b = '0;
    clear_model();
    test_reset();
    test_bnn();
    test_acc();
    test_backpressure();
    test_error();
    test_reset_mid_busy();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
